// File: rtl/main_mem_pipe.sv
// Fully pipelined single-port main-memory model: one request per cycle, reads return
// after a fixed LATENCY with a one-cycle valid strobe; writes share the same port.
module main_mem_pipe #(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              data_valid_o
);

    localparam int unsigned IdxW = $clog2(MEM_WORDS);

    logic [IdxW-1:0]   idx;
    logic              unused_addr;
    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    logic [LATENCY-1:0] valid_q;
    logic [DATA_W-1:0]  data_q [LATENCY];
    logic               s1_valid_d;
    logic [DATA_W-1:0]  s1_data_d;

    // Upper address bits and the byte bit are dropped: addresses alias by design.
    assign idx         = addr_i[IdxW:1];
    assign unused_addr = ^{addr_i[ADDR_W-1:IdxW+1], addr_i[0]};

    // Array contents survive reset; requests seen while rst is high are ignored.
    always_ff @(posedge clk) begin
        if (!rst && enable_i && wr_i) begin
            mem_q[idx] <= data_in_i;
        end
    end

    always_comb begin
        s1_valid_d = enable_i && !wr_i;
        s1_data_d  = mem_q[idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= s1_valid_d;
            data_q[0]  <= s1_data_d;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    always_comb begin
        data_valid_o = valid_q[LATENCY-1];
        data_out_o   = valid_q[LATENCY-1] ? data_q[LATENCY-1] : '0;
    end

endmodule

// File: tb/tb_main_mem_pipe.sv
// Self-checking bench for main_mem_pipe: directed scenarios then random traffic, every
// cycle compared against a reference model of expected returns keyed by cycle number.
module tb_main_mem_pipe;

    localparam int L = 4;
    localparam int Words = 1024;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;

    main_mem_pipe #(
        .LATENCY  (L),
        .ADDR_W   (16),
        .DATA_W   (16),
        .MEM_WORDS(Words)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable),
        .wr_i        (wr),
        .addr_i      (addr),
        .data_in_i   (data_in),
        .data_out_o  (data_out),
        .data_valid_o(data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ref_mem [Words];
    bit          exp_v [int];
    logic [15:0] exp_d [int];
    int          cyc;
    int          checks;
    int          passes;

    task automatic check(input string tag, input logic ev, input logic [15:0] ed);
        checks++;
        assert (data_valid === ev && data_out === ed) passes++;
        else $error("FAIL %s cyc=%0d got valid=%b data=%h expected valid=%b data=%h",
                    tag, cyc, data_valid, data_out, ev, ed);
    endtask

    // One clock cycle: present a request, update the model, then compare the new cycle.
    task automatic step(input logic r, input logic en, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
        int          ix;
        logic        ev;
        logic [15:0] ed;
        rst     = r;
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        ix      = (int'(a) / 2) % Words;
        if (r) begin
            #1;
            check("rst_async", 1'b0, 16'h0000);
            exp_v.delete();
            exp_d.delete();
        end else if (en) begin
            if (w) begin
                ref_mem[ix] = d;
            end else begin
                exp_v[cyc + L] = 1'b1;
                exp_d[cyc + L] = ref_mem[ix];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        ev = exp_v.exists(cyc);
        ed = ev ? exp_d[cyc] : 16'h0000;
        check("cycle", ev, ed);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        logic [15:0] a;
        cyc     = 0;
        checks  = 0;
        passes  = 0;
        rst     = 1'b0;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;
        for (int i = 0; i < Words; i++) ref_mem[i] = 16'h0000;
        #2;

        // Reset held two cycles with read requests present, then quiet after release
        step(1'b1, 1'b1, 1'b0, 16'h0046, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 16'h0046, 16'h0000);
        idle(4);

        // Preload the words used by the random phase
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'(2 * i), 16'($urandom));
        end
        idle(L);

        // Write then read, plus odd byte address hitting the same word
        step(1'b0, 1'b1, 1'b1, 16'h0046, 16'h4567);
        step(1'b0, 1'b1, 1'b0, 16'h0046, 16'h0000);
        idle(L + 1);
        step(1'b0, 1'b1, 1'b0, 16'h0047, 16'h0000);
        idle(L + 1);

        // Block fill
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 16'(16'h0040 + 2 * i), 16'(16'h1000 + i));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'(16'h0040 + 2 * i), 16'h0000);
        idle(L + 2);

        // Write between two reads of the same word
        step(1'b0, 1'b1, 1'b1, 16'h0010, 16'h1111);
        step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 16'h0010, 16'h2222);
        step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(L + 2);

        // Reset with three reads in flight, then re-read those words
        step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0042, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0044, 16'h0000);
        step(1'b1, 1'b1, 1'b1, 16'h0040, 16'hDEAD);
        idle(L + 2);
        step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0042, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0044, 16'h0000);
        idle(L + 2);

        // Reset arriving while data_valid is high must drop it at once
        step(1'b0, 1'b1, 1'b0, 16'h0046, 16'h0000);
        idle(L - 1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        idle(L + 1);

        // Aliasing beyond the array size
        step(1'b0, 1'b1, 1'b1, 16'h0002, 16'hBEEF);
        step(1'b0, 1'b1, 1'b0, 16'h0802, 16'h0000);
        idle(L + 1);

        // Random traffic on preloaded words with random upper alias bits
        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom) & 16'hF87F;
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0), a, 16'($urandom));
        end
        idle(L + 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
